// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - multi-cycle, multi-mode sequential shifter with start/busy/done handshake (optional rotate: SHIFT_SEQ_ROTATE_EN)
module shift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fill,
  output logic [WIDTH-1:0] data_out,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // Next-state and datapath: load on accepted start, one shift per SHIFT cycle
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    mode_d      = mode_q;
    rem_d       = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          mode_d  = mode;
          rem_d   = (amount > WIDTH_C) ? WIDTH_C : amount;
          state_d = (amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_valid_d = 1'b1;
        rem_d       = rem_q - ONE_C;
        case (mode_q)
          MODE_LSR: begin
            out_d  = data_q[0];
            data_d = {fill, data_q[WIDTH-1:1]};
          end
          MODE_ASR: begin
            out_d  = data_q[0];
            data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          end
`ifdef SHIFT_SEQ_ROTATE_EN
          MODE_ROL: begin
            out_d  = data_q[WIDTH-1];
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          end
`endif
          // Logical left; also mode 11 when rotate is not built
          default: begin
            out_d  = data_q[WIDTH-1];
            data_d = {data_q[WIDTH-2:0], fill};
          end
        endcase
        if (rem_q == ONE_C) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and working registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= 2'b00;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      rem_q       <= rem_d;
    end
  end

  assign data_out  = data_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - self-checking bench for shift_seq_unit against a behavioural shift model
module tb_shift_seq_unit;

  localparam int W = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] amount;
  logic [W-1:0]  data_in;
  logic          fill;
  logic [W-1:0]  data_out;
  logic          out;
  logic          out_valid;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  int mw;
  int mo;

  shift_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amount(amount),
    .data_in(data_in), .fill(fill), .data_out(data_out), .out(out),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One shift of the reference word, from the mode definitions
  task automatic model_step(input logic [1:0] m, input int f);
    int mask;
    int msb;
    mask = (1 << W) - 1;
    msb  = (mw >> (W - 1)) & 1;
    if (m == 2'b01) begin
      mo = mw & 1;
      mw = (mw >> 1) | (f << (W - 1));
    end else if (m == 2'b10) begin
      mo = mw & 1;
      mw = (mw >> 1) | (msb << (W - 1));
    end else begin
`ifdef SHIFT_SEQ_ROTATE_EN
      if (m == 2'b11) begin
        mo = msb;
        mw = ((mw << 1) | msb) & mask;
      end else begin
        mo = msb;
        mw = ((mw << 1) | f) & mask;
      end
`else
      mo = msb;
      mw = ((mw << 1) | f) & mask;
`endif
    end
  endtask

  // fmode: 0/1 constant fill, 2 random fill. noisy: disturb inputs and pulse start while busy.
  task automatic run_op(input logic [W-1:0] d, input logic [1:0] m, input int a,
                        input int fmode, input bit noisy);
    int n;
    int f;
    n = (a > W) ? W : a;
    data_in = d;
    mode    = m;
    amount  = CW'(a);
    start   = 1'b1;
    tick();
    start = 1'b0;
    mw = d;
    chk("load_data", data_out, d);
    chk("load_busy", busy, 1'b1);
    chk("load_valid", out_valid, 1'b0);
    chk("load_done", done, (n == 0));
    for (int k = 1; k <= n; k++) begin
      f = (fmode == 2) ? int'($urandom_range(1, 0)) : fmode;
      fill = f[0];
      if (noisy) begin
        start   = 1'b1;
        data_in = W'($urandom);
        mode    = 2'($urandom);
        amount  = CW'($urandom);
      end
      tick();
      model_step(m, f);
      chk("shift_data", data_out, mw);
      chk("shift_out", out, mo);
      chk("shift_valid", out_valid, 1'b1);
      chk("shift_done", done, (k == n));
      chk("shift_busy", busy, 1'b1);
    end
    if (noisy) start = 1'b1;
    tick();
    start = 1'b0;
    chk("exit_done", done, 1'b0);
    chk("exit_busy", busy, 1'b0);
    chk("exit_valid", out_valid, 1'b0);
    chk("exit_data", data_out, mw);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 2'b00;
    amount  = '0;
    data_in = '0;
    fill    = 1'b0;
    tick();
    tick();
    chk("rst_data", data_out, 0);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a 5-step shift
    data_in = 8'h3C;
    mode    = 2'b00;
    amount  = CW'(5);
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_data", data_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_done", done, 0);
      chk("midrst_idle", busy, 0);
    end

    // Logical left walking one
    run_op(8'h01, 2'b00, 8, 0, 1'b0);
    chk("lsl_final", data_out, 8'h00);
    chk("lsl_last_out", out, 1'b1);

    // Arithmetic right, fill ignored
    run_op(8'h90, 2'b10, 3, 0, 1'b0);
    chk("asr_final_f0", data_out, 8'hF2);
    run_op(8'h90, 2'b10, 3, 1, 1'b0);
    chk("asr_final_f1", data_out, 8'hF2);

    // Mode 11: rotate when built, logical left otherwise
    run_op(8'hA5, 2'b11, 8, 0, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("rol_final", data_out, 8'hA5);
`else
    chk("rol_off_final", data_out, 8'h00);
`endif

    // Logical right with fill=1
    run_op(8'h81, 2'b01, 4, 1, 1'b0);
    chk("lsr_final", data_out, 8'hF8);

    // Boundaries: zero amount and clamped amount
    run_op(8'h5A, 2'b00, 0, 0, 1'b0);
    chk("amt0_data", data_out, 8'h5A);
    run_op(8'h0F, 2'b01, 15, 1, 1'b0);
    chk("amt15_final", data_out, 8'hFF);

    // Starts during SHIFT and DONE ignored; back-to-back start accepted
    run_op(8'hC3, 2'b00, 3, 1, 1'b1);
    run_op(8'h3C, 2'b01, 2, 0, 1'b0);
    chk("b2b_final", data_out, 8'h0F);

    // Randomized operations with input noise while busy
    for (int t = 0; t < 40; t++) begin
      run_op(W'($urandom), 2'($urandom), int'($urandom_range(15, 0)), 2, 1'($urandom));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
        tick();
        chk("idle_hold_done", done, 0);
        chk("idle_hold_data", data_out, mw);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Parametrised sequential shifter: loads a WIDTH-bit word, then shifts it one position per clock for a programmable number of steps in a selectable mode, emitting each bit shifted out. It generalises the 8-bit single-shot left shifter into a multi-cycle, multi-mode unit with a start/busy/done handshake. It sits in the datapath wherever serialisation or variable shifts over several cycles are needed.

## Interface
- WIDTH, 8: data word width, at least 2.
- CNT_W, $clog2(WIDTH+1): width of the shift-amount port. Derived; do not override.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- start  in  1  request. Accepted only in IDLE.
- mode  in  2  shift mode, sampled with start:
  - 00 logical left
  - 01 logical right
  - 10 arithmetic right
  - 11 rotate left
- amount  in  CNT_W  number of single-bit shifts, sampled with start.
- data_in  in  WIDTH  word loaded on an accepted start.
- fill  in  1  bit shifted into the vacated position in logical modes. Sampled every shift cycle.
- data_out  out  WIDTH  working register. Holds the result after done.
- out  out  1  bit shifted out on the most recent shift.
- out_valid  out  1  high for exactly the cycles in which out was updated.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse marking completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset, taking priority over everything: state=IDLE, and data_out, out, out_valid, busy and done all 0. A reset mid-operation abandons the operation with no done pulse.
- IDLE, start=1:
  - data_out←data_in.
  - mode and amount are latched.
  - remaining←min(amount, WIDTH). Amounts above WIDTH clamp to WIDTH.
  - Next state is SHIFT if remaining>0, otherwise DONE.
- IDLE, start=0: hold all registers. done=0, out_valid=0.
- SHIFT: each cycle performs one shift, sets out_valid=1 and decrements remaining. Per mode:
  - Logical left: out←data_out[WIDTH-1]; data_out←{data_out[WIDTH-2:0], fill}.
  - Logical right: out←data_out[0]; data_out←{fill, data_out[WIDTH-1:1]}.
  - Arithmetic right: out←data_out[0]; the MSB is replicated and fill is ignored.
  - Rotate left: out←data_out[WIDTH-1]; data_out←{data_out[WIDTH-2:0], data_out[WIDTH-1]}.
- SHIFT exit: the cycle in which remaining goes 1→0 transitions to DONE.
- DONE: done=1 and out_valid=0 for one cycle, then IDLE. data_out and out hold.
- start is ignored while busy=1, including in DONE. A start coincident with the done pulse is dropped.
- Inputs mode, amount and data_in may change freely while busy. Only the values latched at the accepted start are used.

## Timing
- Let E0 be the clock edge at which start is accepted.
- data_out equals data_in after E0. busy rises after E0.
- Shifts occur on edges E1..En, where n is the clamped amount. out and out_valid are registered and reflect the shift at each edge.
- done is high in the cycle after En and low after En+1. busy falls together with done.
- Total start-to-done latency is n+1 cycles.
- For amount=0, done is high in the cycle right after E0 and data_out equals data_in.
- Back-to-back throughput: the earliest next accepted start is edge En+2.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined: mode 11 performs rotate left as specified.
- SHIFT_SEQ_ROTATE_EN undefined: rotate logic is not built, and mode 11 behaves exactly as mode 00 (logical left with fill). All other modes are unaffected.

## Test plan
- Reset: WIDTH=8. Assert rst_n=0 mid-SHIFT with amount=5 → after that edge data_out=0, busy=0, out_valid=0. No done pulse follows.
- Logical left: data_in=8'h01, amount=8, fill=0 → data_out walks 02,04,…,80,00. out is 0 for 7 shifts, then 1 on the 8th. done is 9 cycles after start.
- Arithmetic right: data_in=8'h90, amount=3 → final data_out=8'hF2, out sequence 0,0,0. Repeat with fill=1 → identical result.
- Rotate left, macro defined: data_in=8'hA5, amount=8 → final data_out=8'hA5, out sequence 1,0,1,0,0,1,0,1. With the macro undefined and fill=0 → final data_out=8'h00.
- Boundaries:
  - amount=0 → done one cycle after start, data_out=data_in, out_valid never high.
  - amount=15 → clamped to 8 shifts.
- Handshake: pulse start during SHIFT and again during DONE → both ignored. Start one cycle after done → accepted.
